mem_burst_master: RTL

//  Initiator for the main-memory bus (rd_mem/wr_mem/addr_mem/shared data/ready_mem).
//  - Accepts single or burst read/write requests from a client (cache fill/evict logic).
//  - Sequences the memory strobes, drives or releases the shared data bus, streams read data back.
//  - Memory side: registers on negedge clk; drives data only while rd_mem=1; ready_mem = ~(rd_mem|wr_mem).

---
 rtl/mem_burst_master.sv | 116 +++++++++++
 1 files changed

// File: rtl/mem_burst_master.sv
// mem_burst_master: bus initiator for the main-memory port.
// Takes single or burst read/write requests from a client (cache fill/evict logic),
// sequences rd_mem/wr_mem/addr_mem, drives the shared data bus only while writing,
// and streams read beats back one cycle after their address was presented.
// Every transaction ends with a one-cycle TURN state so the bus is idle between
// a write and a following read (no contention on the shared data lines).

module mem_burst_master #(
  parameter int AWIDTH = 9,
  parameter int DWIDTH = 8,
  parameter int LWIDTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [AWIDTH-1:0] req_addr,
  input  logic [LWIDTH-1:0] req_len,
  input  logic [DWIDTH-1:0] wdata,
  output logic              wdata_ack,
  output logic [DWIDTH-1:0] rdata,
  output logic              rdata_valid,
  output logic              done,
  output logic              busy,
  output logic              rd_mem,
  output logic              wr_mem,
  output logic [AWIDTH-1:0] addr_mem,
  inout  wire  [DWIDTH-1:0] data,
  input  logic              ready_mem
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    TURN  = 2'd3
  } state_t;

  localparam logic [AWIDTH-1:0] ADDR_STEP = {{(AWIDTH-1){1'b0}}, 1'b1};
  localparam logic [LWIDTH-1:0] CNT_STEP  = {{(LWIDTH-1){1'b0}}, 1'b1};

  state_t            state;
  logic [LWIDTH-1:0] cnt;

  // Main sequencer: accepts a request, walks the burst one beat per cycle, then turns the bus around
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      rd_mem      <= 1'b0;
      wr_mem      <= 1'b0;
      addr_mem    <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && ready_mem) begin
            addr_mem <= req_addr;
            cnt      <= req_len;
            wr_mem   <= req_write;
            rd_mem   <= ~req_write;
            state    <= req_write ? WRITE : READ;
          end
        end
        WRITE: begin
          if (cnt == '0) begin
            wr_mem <= 1'b0;
            done   <= 1'b1;
            state  <= TURN;
          end else begin
            addr_mem <= addr_mem + ADDR_STEP;
            cnt      <= cnt - CNT_STEP;
          end
        end
        READ: begin
          rdata       <= data;
          rdata_valid <= 1'b1;
          if (cnt == '0) begin
            rd_mem <= 1'b0;
            done   <= 1'b1;
            state  <= TURN;
          end else begin
            addr_mem <= addr_mem + ADDR_STEP;
            cnt      <= cnt - CNT_STEP;
          end
        end
        TURN: begin
          rdata_valid <= 1'b0;
          state       <= IDLE;
        end
        default: begin
          rd_mem      <= 1'b0;
          wr_mem      <= 1'b0;
          rdata_valid <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  // New requests are only taken from IDLE and only while no other master owns the bus
  assign req_ready = (state == IDLE) && ready_mem;

  // The client's current write beat goes straight onto the bus during WRITE cycles
  assign wdata_ack = (state == WRITE);

  assign busy = (state != IDLE);

  // Drive the shared bus only while our write strobe is up; otherwise leave it to memory
  assign data = wr_mem ? wdata : {DWIDTH{1'bz}};

endmodule
